// File: rtl/bcsa_pkg.sv
// ----------------------------------------------------------------------------
// bcsa_pkg
// Shared definitions for the block carry-select adder recovery unit:
//   - state_t     : recovery FSM states (IDLE, SCAN, DONE)
//   - BLK_W       : width of one adder block (2 bits)
//   - field_count : number of compared fields for a given operand width
//                   (WIDTH/2 two-bit blocks plus the carry-out bit)
// ----------------------------------------------------------------------------
package bcsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BLK_W = 2;

    function automatic int field_count(input int width);
        return width / BLK_W + 1;
    endfunction

endpackage

// File: rtl/bcsa_blk_resolve.sv
// ----------------------------------------------------------------------------
// bcsa_blk_resolve
// Combinational resolver for one SCAN cycle: adds BLK_PER_CYC two-bit blocks
// of the operands with a rippling carry and counts the blocks whose exact
// bits differ from the approximate sum.
//
// Ports:
//   a_slc, b_slc  in   operand bits of the current block group
//   approx_slc    in   approximate-sum bits of the same group
//   carry_in      in   carry registered from the previous group
//   exact_bits    out  exact sum bits of the group
//   carry_out     out  carry out of the most significant block
//   mism_cnt      out  number of mismatched blocks in the group
// ----------------------------------------------------------------------------
module bcsa_blk_resolve
    import bcsa_pkg::*;
#(
    parameter  int BLK_PER_CYC = 4,
    localparam int GRP_W       = BLK_PER_CYC * BLK_W,
    localparam int MIS_W       = $clog2(BLK_PER_CYC + 1)
) (
    input  logic [GRP_W-1:0] a_slc,
    input  logic [GRP_W-1:0] b_slc,
    input  logic [GRP_W-1:0] approx_slc,
    input  logic             carry_in,
    output logic [GRP_W-1:0] exact_bits,
    output logic             carry_out,
    output logic [MIS_W-1:0] mism_cnt
);

    logic carry_rip;

    always_comb begin
        carry_rip  = carry_in;
        exact_bits = '0;
        mism_cnt   = '0;
        // NOTE: blocking assignments are deliberate here: carry_rip must take
        // its new value inside the same loop iteration to ripple bit by bit.
        for (int i = 0; i < GRP_W; i++) begin
            exact_bits[i] = a_slc[i] ^ b_slc[i] ^ carry_rip;
            carry_rip     = (a_slc[i] & b_slc[i]) | (carry_rip & (a_slc[i] ^ b_slc[i]));
        end
        carry_out = carry_rip;
        for (int k = 0; k < BLK_PER_CYC; k++) begin
            if (exact_bits[k*BLK_W +: BLK_W] != approx_slc[k*BLK_W +: BLK_W]) begin
                mism_cnt = mism_cnt + MIS_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcsa_recovery_unit.sv
// ----------------------------------------------------------------------------
// bcsa_recovery_unit
// Variable-latency checker/corrector for the 32-bit block carry-select
// approximate adder. Captures the operands with the approximate sum, resolves
// the exact sum block-serially (BLK_PER_CYC two-bit blocks per SCAN cycle,
// carry registered between cycles) and reports exact sum plus error metrics.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                  operands (WIDTH bits)
//   approx_sum            approximate sum under test (WIDTH+1 bits)
//   out_valid / out_ready result handshake; results hold until accepted
//   exact_sum             exact a+b (WIDTH+1 bits)
//   err                   exact_sum != approx_sum
//   err_mag               |exact_sum - approx_sum|
//   err_blocks            number of mismatched fields (blocks + carry-out)
//   stat_ops, stat_errs   saturating completed/erroneous operation counters
//
// Optional feature macro: BCSA_ERR_STATS_EN
//   defined   : stat_ops / stat_errs count DONE handshakes (all / err=1)
//   undefined : no counter registers, both outputs tied to 0
// ----------------------------------------------------------------------------
module bcsa_recovery_unit
    import bcsa_pkg::*;
#(
    parameter  int WIDTH       = 32,
    parameter  int BLK_PER_CYC = 4,
    localparam int CNT_W       = $clog2(field_count(WIDTH) + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH:0]   approx_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   exact_sum,
    output logic             err,
    output logic [WIDTH:0]   err_mag,
    output logic [CNT_W-1:0] err_blocks,
    output logic [31:0]      stat_ops,
    output logic [31:0]      stat_errs
);

    localparam int GRP_W    = BLK_PER_CYC * BLK_W;
    localparam int SCAN_CYC = WIDTH / GRP_W;
    localparam int IDX_W    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam int MIS_W    = $clog2(BLK_PER_CYC + 1);

    generate
        if ((WIDTH <= 0) || (BLK_PER_CYC <= 0) || ((WIDTH % GRP_W) != 0)) begin : g_bad_width
            $error("bcsa_recovery_unit: WIDTH must be a positive multiple of 2*BLK_PER_CYC");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     apx_q, apx_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]     exact_q, exact_d;
    logic               err_q, err_d;
    logic [WIDTH:0]     err_mag_q, err_mag_d;
    logic [CNT_W-1:0]   err_blocks_q, err_blocks_d;

    // ------------------------------------------------------------------
    // Current block group: constant part-selects steered by the group index
    // ------------------------------------------------------------------
    logic [GRP_W-1:0]   grp_a, grp_b, grp_apx;
    logic [GRP_W-1:0]   blk_exact;
    logic               blk_co;
    logic [MIS_W-1:0]   blk_mis;

    always_comb begin
        grp_a   = '0;
        grp_b   = '0;
        grp_apx = '0;
        for (int g = 0; g < SCAN_CYC; g++) begin
            if (idx_q == IDX_W'(g)) begin
                grp_a   = a_q[g*GRP_W +: GRP_W];
                grp_b   = b_q[g*GRP_W +: GRP_W];
                grp_apx = apx_q[g*GRP_W +: GRP_W];
            end
        end
    end

    bcsa_blk_resolve #(
        .BLK_PER_CYC (BLK_PER_CYC)
    ) u_resolve (
        .a_slc      (grp_a),
        .b_slc      (grp_b),
        .approx_slc (grp_apx),
        .carry_in   (carry_q),
        .exact_bits (blk_exact),
        .carry_out  (blk_co),
        .mism_cnt   (blk_mis)
    );

    // Partial sum with the current group inserted, and the full-width view
    // used on the last SCAN cycle.
    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH:0]     exact_nx;
    logic [CNT_W-1:0]   total_mis;

    always_comb begin
        acc_nx = acc_q;
        for (int g = 0; g < SCAN_CYC; g++) begin
            if (idx_q == IDX_W'(g)) begin
                acc_nx[g*GRP_W +: GRP_W] = blk_exact;
            end
        end
        exact_nx  = {blk_co, acc_nx};
        // Carry-out bit counts as the extra compared field.
        total_mis = cnt_q + CNT_W'(blk_mis) + CNT_W'(blk_co != apx_q[WIDTH]);
    end

    logic out_hs;
    assign out_hs = (state_q == DONE) && out_valid_q && out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d starts from its _q value so no path leaves a signal
        // unassigned; otherwise this block would infer latches.
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        a_d          = a_q;
        b_d          = b_q;
        apx_d        = apx_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        exact_d      = exact_q;
        err_d        = err_q;
        err_mag_d    = err_mag_q;
        err_blocks_d = err_blocks_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    apx_d      = approx_sum;
                    carry_d    = 1'b0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    acc_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                carry_d = blk_co;
                acc_d   = acc_nx;
                cnt_d   = cnt_q + CNT_W'(blk_mis);
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(SCAN_CYC - 1)) begin
                    exact_d      = exact_nx;
                    err_mag_d    = (exact_nx >= apx_q) ? (exact_nx - apx_q) : (apx_q - exact_nx);
                    err_blocks_d = total_mis;
                    err_d        = (total_mis != '0);
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

`ifdef BCSA_ERR_STATS_EN
    logic [31:0] stat_ops_q, stat_ops_d;
    logic [31:0] stat_errs_q, stat_errs_d;

    always_comb begin
        stat_ops_d  = stat_ops_q;
        stat_errs_d = stat_errs_q;
        if (out_hs) begin
            if (stat_ops_q != 32'hFFFF_FFFF) begin
                stat_ops_d = stat_ops_q + 32'd1;
            end
            if (err_q && (stat_errs_q != 32'hFFFF_FFFF)) begin
                stat_errs_d = stat_errs_q + 32'd1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            // NOTE: datapath registers are reset as well, so a reset mid-SCAN
            // leaves no trace of the discarded operation on the outputs.
            a_q          <= '0;
            b_q          <= '0;
            apx_q        <= '0;
            carry_q      <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            exact_q      <= '0;
            err_q        <= 1'b0;
            err_mag_q    <= '0;
            err_blocks_q <= '0;
`ifdef BCSA_ERR_STATS_EN
            stat_ops_q   <= '0;
            stat_errs_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
            apx_q        <= apx_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            exact_q      <= exact_d;
            err_q        <= err_d;
            err_mag_q    <= err_mag_d;
            err_blocks_q <= err_blocks_d;
`ifdef BCSA_ERR_STATS_EN
            stat_ops_q   <= stat_ops_d;
            stat_errs_q  <= stat_errs_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign exact_sum  = exact_q;
    assign err        = err_q;
    assign err_mag    = err_mag_q;
    assign err_blocks = err_blocks_q;

`ifdef BCSA_ERR_STATS_EN
    assign stat_ops   = stat_ops_q;
    assign stat_errs  = stat_errs_q;
`else
    assign stat_ops   = 32'd0;
    assign stat_errs  = 32'd0;
`endif

endmodule

// File: tb/tb_bcsa_recovery_unit.sv
// ----------------------------------------------------------------------------
// tb_bcsa_recovery_unit
// Directed testbench for bcsa_recovery_unit at default parameters
// (WIDTH=32, BLK_PER_CYC=4). Expected values are hand-computed constants.
// Statistics expectations follow BCSA_ERR_STATS_EN.
// ----------------------------------------------------------------------------
module tb_bcsa_recovery_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [32:0] approx_sum = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] exact_sum;
    logic        err;
    logic [32:0] err_mag;
    logic [4:0]  err_blocks;
    logic [31:0] stat_ops;
    logic [31:0] stat_errs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcsa_recovery_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .exact_sum  (exact_sum),
        .err        (err),
        .err_mag    (err_mag),
        .err_blocks (err_blocks),
        .stat_ops   (stat_ops),
        .stat_errs  (stat_errs)
    );

    // Drives one operation and waits (bounded) for out_valid.
    // lat = number of clock edges after the acceptance edge.
    task automatic issue(input logic [31:0] ta, input logic [31:0] tb,
                         input logic [32:0] tapx, output int lat);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        a = ta; b = tb; approx_sum = tapx; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (exact_sum !== 33'h0) begin n_fail++; $display("FAIL rst_exact_sum: got %h, required 0", exact_sum); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err); end
        n_checks++; if (err_mag !== 33'h0) begin n_fail++; $display("FAIL rst_err_mag: got %h, required 0", err_mag); end
        n_checks++; if (err_blocks !== 5'd0) begin n_fail++; $display("FAIL rst_err_blocks: got %0d, required 0", err_blocks); end
        n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL rst_stat_ops: got %0d, required 0", stat_ops); end
        n_checks++; if (stat_errs !== 32'd0) begin n_fail++; $display("FAIL rst_stat_errs: got %0d, required 0", stat_errs); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Speculative-carry miss: 3+1 = 4, approx 0, block 1 mismatches.
    task automatic test_carry_miss();
        int lat;
        issue(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL s1_latency: got %0d cycles, required 4", lat); end
        n_checks++; if (exact_sum !== 33'h0_0000_0004) begin n_fail++; $display("FAIL s1_exact_sum: got %h, required 000000004", exact_sum); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL s1_err: got %b, required 1", err); end
        n_checks++; if (err_mag !== 33'h0_0000_0004) begin n_fail++; $display("FAIL s1_err_mag: got %h, required 000000004", err_mag); end
        n_checks++; if (err_blocks !== 5'd1) begin n_fail++; $display("FAIL s1_err_blocks: got %0d, required 1", err_blocks); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL s1_in_ready_done: got %b, required 0", in_ready); end
        release_result();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL s1_out_valid_drop: got %b, required 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL s1_in_ready_back: got %b, required 1", in_ready); end
    endtask

    task automatic test_exact_match();
        int lat;
        issue(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL s2_latency: got %0d cycles, required 4", lat); end
        n_checks++; if (exact_sum !== 33'h0_2345_6789) begin n_fail++; $display("FAIL s2_exact_sum: got %h, required 023456789", exact_sum); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL s2_err: got %b, required 0", err); end
        n_checks++; if (err_mag !== 33'h0) begin n_fail++; $display("FAIL s2_err_mag: got %h, required 0", err_mag); end
        n_checks++; if (err_blocks !== 5'd0) begin n_fail++; $display("FAIL s2_err_blocks: got %0d, required 0", err_blocks); end
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        issue(32'hFFFF_FFFF, 32'h0000_0001, 33'h0_0000_0000, lat);
        n_checks++; if (exact_sum !== 33'h1_0000_0000) begin n_fail++; $display("FAIL s3_exact_sum: got %h, required 100000000", exact_sum); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL s3_err: got %b, required 1", err); end
        n_checks++; if (err_mag !== 33'h1_0000_0000) begin n_fail++; $display("FAIL s3_err_mag: got %h, required 100000000", err_mag); end
        n_checks++; if (err_blocks !== 5'd1) begin n_fail++; $display("FAIL s3_err_blocks: got %0d, required 1", err_blocks); end
        release_result();
    endtask

    // 0xF0+0x10 = 0x100 vs approx 0x0F0: blocks 2,3,4 differ, |diff| = 0x10.
    task automatic test_backpressure();
        int lat;
        issue(32'h0000_00F0, 32'h0000_0010, 33'h0_0000_00F0, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d cycles, required 4", lat); end
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; approx_sum = 33'h1_2345_6789; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b, required 1", c, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", c, in_ready); end
            n_checks++; if (exact_sum !== 33'h0_0000_0100) begin n_fail++; $display("FAIL bp_exact_sum[%0d]: got %h, required 000000100", c, exact_sum); end
            n_checks++; if (err_mag !== 33'h0_0000_0010) begin n_fail++; $display("FAIL bp_err_mag[%0d]: got %h, required 000000010", c, err_mag); end
            n_checks++; if (err_blocks !== 5'd3) begin n_fail++; $display("FAIL bp_err_blocks[%0d]: got %0d, required 3", c, err_blocks); end
            n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bp_err[%0d]: got %b, required 1", c, err); end
        end
        in_valid = 1'b0;
        release_result();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_release: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_out_valid_release: got %b, required 0", out_valid); end
    endtask

    task automatic test_mid_scan_reset();
        int lat;
        a = 32'h1234_5678; b = 32'h1111_1111; approx_sum = 33'h0_0000_0000; in_valid = 1'b1;
        @(posedge clk); #1;            // acceptance edge
        in_valid = 1'b0;
        @(posedge clk); #1;            // now in the 2nd SCAN cycle
        rst_n = 1'b0;
        #2;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (exact_sum !== 33'h0) begin n_fail++; $display("FAIL mr_exact_sum: got %h, required 0", exact_sum); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL mr_err: got %b, required 0", err); end
        n_checks++; if (err_mag !== 33'h0) begin n_fail++; $display("FAIL mr_err_mag: got %h, required 0", err_mag); end
        n_checks++; if (err_blocks !== 5'd0) begin n_fail++; $display("FAIL mr_err_blocks: got %0d, required 0", err_blocks); end
        n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL mr_stat_ops: got %0d, required 0", stat_ops); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL mr_next_latency: got %0d cycles, required 4", lat); end
        n_checks++; if (exact_sum !== 33'h0_0000_0004) begin n_fail++; $display("FAIL mr_next_exact: got %h, required 000000004", exact_sum); end
        n_checks++; if (err_blocks !== 5'd1) begin n_fail++; $display("FAIL mr_next_err_blocks: got %0d, required 1", err_blocks); end
        release_result();
`ifdef BCSA_ERR_STATS_EN
        n_checks++; if (stat_ops !== 32'd1) begin n_fail++; $display("FAIL mr_next_stat_ops: got %0d, required 1", stat_ops); end
`else
        n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL mr_next_stat_ops: got %0d, required 0", stat_ops); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        apply_reset();
        issue(32'h0000_0003, 32'h0000_0001, 33'h0_0000_0000, lat);
        release_result();
        issue(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, lat);
        release_result();
        issue(32'hFFFF_FFFF, 32'h0000_0001, 33'h0_0000_0000, lat);
        n_checks++; if (exact_sum !== 33'h1_0000_0000) begin n_fail++; $display("FAIL b2b_exact_sum: got %h, required 100000000", exact_sum); end
        release_result();
`ifdef BCSA_ERR_STATS_EN
        n_checks++; if (stat_ops !== 32'd3) begin n_fail++; $display("FAIL b2b_stat_ops: got %0d, required 3", stat_ops); end
        n_checks++; if (stat_errs !== 32'd2) begin n_fail++; $display("FAIL b2b_stat_errs: got %0d, required 2", stat_errs); end
`else
        n_checks++; if (stat_ops !== 32'd0) begin n_fail++; $display("FAIL b2b_stat_ops: got %0d, required 0", stat_ops); end
        n_checks++; if (stat_errs !== 32'd0) begin n_fail++; $display("FAIL b2b_stat_errs: got %0d, required 0", stat_errs); end
`endif
    endtask

    initial begin
        test_reset();
        test_carry_miss();
        test_exact_match();
        test_overflow();
        test_backpressure();
        test_mid_scan_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcsa_recovery_unit.md
Name: bcsa_recovery_unit

Overview:
- Variable-latency checker/corrector placed downstream of the 32-bit block carry-select approximate adder.
- Accepts the operands together with the approximate sum the adder produced for them.
- Recomputes the exact sum block-serially, 2 bits per block, with a registered carry chain.
- Returns the exact sum plus error metrics (error flag, magnitude, count of mismatched blocks) for accuracy characterisation and error recovery.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 2*BLK_PER_CYC, otherwise elaboration error.
- BLK_PER_CYC, 4, number of 2-bit blocks resolved per SCAN cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/approx-sum valid
- in_ready  out  1  unit can accept (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- approx_sum  in  WIDTH+1  approximate sum under test
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- exact_sum  out  WIDTH+1  exact a+b
- err  out  1  exact_sum != approx_sum
- err_mag  out  WIDTH+1  |exact_sum - approx_sum|
- err_blocks  out  clog2(WIDTH/2+2)  mismatched fields: WIDTH/2 two-bit blocks plus the carry-out bit
- stat_ops  out  32  operations completed (see Optional Feature)
- stat_errs  out  32  operations with err=1 (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0.
  - exact_sum, err, err_mag, err_blocks, stat_ops, stat_errs all 0.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_valid & in_ready captures a, b, approx_sum.
  - Clears the carry register, the block index and the mismatch counter.
  - Transitions to SCAN.
- SCAN, block-serial resolution:
  - Each cycle resolves blocks idx .. idx+BLK_PER_CYC-1.
  - Carry ripples combinationally within the cycle; the carry out of the group is registered for the next cycle.
  - Per block i: exact bits = a^b^carry for bits 2i+1:2i; compare with approx_sum[2i+1:2i]; increment the counter on mismatch.
  - Number of SCAN cycles = WIDTH/(2*BLK_PER_CYC); 4 at defaults.
- Last SCAN cycle:
  - exact_sum[WIDTH] = final carry; compared with approx_sum[WIDTH] as the extra field.
  - err_mag is registered: exact-approx if exact>=approx, else approx-exact, at WIDTH+1 bits.
  - err is registered as (mismatch count != 0).
  - Transitions to DONE.
- DONE:
  - out_valid=1; all result outputs are stable until out_valid & out_ready.
  - On that handshake: transition to IDLE; out_valid drops on the next edge.
- Latency and throughput:
  - Acceptance edge to out_valid high: WIDTH/(2*BLK_PER_CYC) cycles; 4 at defaults.
  - No overlap between operations: in_ready=0 throughout SCAN/DONE.
  - Minimum initiation interval: SCAN cycles + 2.
- Boundary conditions:
  - out_ready held low in DONE: the unit stalls indefinitely; results are unchanged.
  - in_valid while not ready: ignored; the inputs are not sampled.
  - a+b overflow: carried in exact_sum[WIDTH]; no wrap.
  - rst_n asserted mid-SCAN/DONE: immediate return to IDLE with reset values; the in-flight operation is discarded and not counted.
  - approx_sum == exact_sum: err=0, err_mag=0, err_blocks=0.

Optional Feature:
- Macro: BCSA_ERR_STATS_EN.
- Defined:
  - stat_ops increments on each DONE output handshake.
  - stat_errs increments on each such handshake when err=1.
  - Both counters saturate at 0xFFFFFFFF and clear only on reset.
- Undefined: no counter registers; stat_ops and stat_errs are tied to 0.

Decomposition:
- Shared package bcsa_pkg: state enum (IDLE/SCAN/DONE), BLK_W=2 constant, and a function returning the field count WIDTH/2+1.
- One natural sub-module: bcsa_blk_resolve.
  - Combinational, BLK_PER_CYC blocks.
  - Inputs: operand slices, approx slice, carry-in.
  - Outputs: exact bits, carry-out, mismatch count.
  - Instantiated once in the SCAN datapath.

Test Plan:
- a=0x00000003, b=0x00000001, approx_sum=0x000000000 (the adder's speculative-carry miss):
  - exact_sum=0x000000004, err=1, err_mag=0x4, err_blocks=1.
  - out_valid exactly 4 cycles after acceptance.
- a=0x12345678, b=0x11111111, approx_sum=0x023456789 -> exact_sum=0x023456789, err=0, err_mag=0, err_blocks=0.
- a=0xFFFFFFFF, b=0x00000001, approx_sum=0x000000000 -> exact_sum=0x100000000, err=1, err_mag=0x100000000, err_blocks=1 (carry-out field only).
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  - Outputs stable; in_ready=0 throughout.
  - Concurrent in_valid is ignored.
  - Release: one handshake, then in_ready=1 next cycle.
- Reset: drive rst_n low during the 2nd SCAN cycle.
  - All outputs return to reset values asynchronously.
  - A next operation issued after reset produces the correct result.
- With BCSA_ERR_STATS_EN: run scenarios 1-3 back-to-back -> stat_ops=3, stat_errs=2.
- Without BCSA_ERR_STATS_EN: stat_ops and stat_errs read 0 throughout.
